// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   MEM -> WB pipeline register for a multi-lane writeback datapath.
//   Captures per-lane destination/enable/data plus the hi/lo write request.
//   Supports hold, bubble insertion and flush, and counts inserted bubbles.
//
//   Update priority on each rising edge: rst > flush > bubble > hold > load.
//     bubble : stall[STAGE]=1, stall[STAGE+1]=0 -> stage cleared, counter +1
//     hold   : stall[STAGE]=1, stall[STAGE+1]=1 -> stage retained
//     load   : stall[STAGE]=0                   -> stage takes mem_* inputs
//     flush  : cleared like a bubble, counter untouched
//
//   On load, when several enabled lanes target the same register (address 0
//   included), only the highest-numbered lane keeps its write enable.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   stall[5:0], flush      pipeline control
//   mem_wd/mem_wreg/mem_wdata   per-lane writeback request from MEM
//   mem_hi/mem_lo/mem_hilo      hi/lo write request from MEM
//   wb_*                   registered copies towards WB
//   wb_valid               stage holds a loaded instruction group
//   bubble_cnt             saturating count of bubbles inserted here
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int LANES = 1,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int STAGE = 4,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [LANES*AW-1:0]   mem_wd,
    input  logic [LANES-1:0]      mem_wreg,
    input  logic [LANES*DW-1:0]   mem_wdata,
    input  logic [DW-1:0]         mem_hi,
    input  logic [DW-1:0]         mem_lo,
    input  logic                  mem_hilo,
    output logic [LANES*AW-1:0]   wb_wd,
    output logic [LANES-1:0]      wb_wreg,
    output logic [LANES*DW-1:0]   wb_wdata,
    output logic [DW-1:0]         wb_hi,
    output logic [DW-1:0]         wb_lo,
    output logic                  wb_hilo,
    output logic                  wb_valid,
    output logic [CW-1:0]         bubble_cnt
);

    localparam int NEXT = STAGE + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [LANES*AW-1:0]  wd_reg;
    logic [LANES-1:0]     wreg_reg;
    logic [LANES*DW-1:0]  wdata_reg;
    logic [DW-1:0]        hi_reg;
    logic [DW-1:0]        lo_reg;
    logic                 hilo_reg;
    logic                 valid_reg;
    logic [CW-1:0]        cnt_reg;

    logic                 stall_here;
    logic                 bubble;

    assign stall_here = stall[STAGE];
    assign bubble     = stall[STAGE] & ~stall[NEXT];

    // hit[i][j]: a higher lane j writes the same register as lane i, so
    // lane i's write is shadowed and must be dropped.
    logic [LANES-1:0][LANES-1:0] hit;
    logic [LANES-1:0]            wreg_dedup;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        for (genvar gj = 0; gj < LANES; gj++) begin : g_other
            if (gj > gi) begin : g_higher
                assign hit[gi][gj] = mem_wreg[gi] & mem_wreg[gj] &
                                     (mem_wd[gi*AW +: AW] == mem_wd[gj*AW +: AW]);
            end else begin : g_lower
                assign hit[gi][gj] = 1'b0;
            end
        end
        assign wreg_dedup[gi] = mem_wreg[gi] & ~(|hit[gi]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_reg    <= '0;
            wreg_reg  <= '0;
            wdata_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            hilo_reg  <= 1'b0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (flush || bubble) begin
            wd_reg    <= '0;
            wreg_reg  <= '0;
            wdata_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            hilo_reg  <= 1'b0;
            valid_reg <= 1'b0;
            // A flush clears the stage but is not a bubble.
            if (!flush && cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else if (!stall_here) begin
            wd_reg    <= mem_wd;
            wreg_reg  <= wreg_dedup;
            wdata_reg <= mem_wdata;
            hi_reg    <= mem_hi;
            lo_reg    <= mem_lo;
            hilo_reg  <= mem_hilo;
            valid_reg <= 1'b1;
        end
        // Remaining case is hold: every register keeps its value.
    end

    assign wb_wd      = wd_reg;
    assign wb_wreg    = wreg_reg;
    assign wb_wdata   = wdata_reg;
    assign wb_hi      = hi_reg;
    assign wb_lo      = lo_reg;
    assign wb_hilo    = hilo_reg;
    assign wb_valid   = valid_reg;
    assign bubble_cnt = cnt_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//   Directed bench for mem_wb_stage. Two instances share clock/reset/stall/
//   flush: u_one (LANES=1, default widths) and u_two (LANES=2, CW=2) for the
//   collision, address-0 and counter saturation cases.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] mem_hi, mem_lo;
    logic        mem_hilo;

    // single-lane instance
    logic [4:0]  wd1;
    logic        wreg1;
    logic [31:0] wdata1;
    logic [4:0]  o_wd1;
    logic        o_wreg1;
    logic [31:0] o_wdata1, o_hi1, o_lo1;
    logic        o_hilo1, o_valid1;
    logic [15:0] o_cnt1;

    // two-lane instance
    logic [9:0]  wd2;
    logic [1:0]  wreg2;
    logic [63:0] wdata2;
    logic [9:0]  o_wd2;
    logic [1:0]  o_wreg2;
    logic [63:0] o_wdata2;
    logic [31:0] o_hi2, o_lo2;
    logic        o_hilo2, o_valid2;
    logic [1:0]  o_cnt2;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    mem_wb_stage u_one (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wd(wd1), .mem_wreg(wreg1), .mem_wdata(wdata1),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_hilo(mem_hilo),
        .wb_wd(o_wd1), .wb_wreg(o_wreg1), .wb_wdata(o_wdata1),
        .wb_hi(o_hi1), .wb_lo(o_lo1), .wb_hilo(o_hilo1),
        .wb_valid(o_valid1), .bubble_cnt(o_cnt1)
    );

    mem_wb_stage #(.LANES(2), .CW(2)) u_two (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wd(wd2), .mem_wreg(wreg2), .mem_wdata(wdata2),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_hilo(mem_hilo),
        .wb_wd(o_wd2), .wb_wreg(o_wreg2), .wb_wdata(o_wdata2),
        .wb_hi(o_hi2), .wb_lo(o_lo2), .wb_hilo(o_hilo2),
        .wb_valid(o_valid2), .bubble_cnt(o_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_one_clear(input string tag);
        check({tag, " wd"},    64'(o_wd1),    64'd0);
        check({tag, " wreg"},  64'(o_wreg1),  64'd0);
        check({tag, " wdata"}, 64'(o_wdata1), 64'd0);
        check({tag, " hi"},    64'(o_hi1),    64'd0);
        check({tag, " lo"},    64'(o_lo1),    64'd0);
        check({tag, " hilo"},  64'(o_hilo1),  64'd0);
        check({tag, " valid"}, 64'(o_valid1), 64'd0);
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0;
        mem_hi = '0; mem_lo = '0; mem_hilo = 1'b0;
        wd1 = '0; wreg1 = 1'b0; wdata1 = '0;
        wd2 = '0; wreg2 = '0; wdata2 = '0;

        // Reset state
        tick();
        rst = 1'b0;
        check_one_clear("reset one");
        check("reset cnt1",   64'(o_cnt1),   64'd0);
        check("reset valid2", 64'(o_valid2), 64'd0);
        check("reset cnt2",   64'(o_cnt2),   64'd0);
        $display("step reset done");

        // Load, 1-cycle latency; two-lane collision on address 7
        wd1 = 5'd3; wreg1 = 1'b1; wdata1 = 32'hDEADBEEF;
        wd2 = {5'd7, 5'd7}; wreg2 = 2'b11; wdata2 = {32'h22222222, 32'h11111111};
        #1;
        check("no comb path valid", 64'(o_valid1), 64'd0);
        tick();
        check("load wd",    64'(o_wd1),    64'd3);
        check("load wreg",  64'(o_wreg1),  64'd1);
        check("load wdata", 64'(o_wdata1), 64'hDEADBEEF);
        check("load valid", 64'(o_valid1), 64'd1);
        check("collide wreg",  64'(o_wreg2),  64'b10);
        check("collide wd",    64'(o_wd2),    64'(10'b00111_00111));
        check("collide wdata", 64'(o_wdata2), 64'h22222222_11111111);
        $display("step load/collision done");

        // Hold for 3 cycles while inputs change
        wd1 = 5'd9; wdata1 = 32'h12345678; wreg1 = 1'b0;
        stall = 6'b110000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold wd",    64'(o_wd1),    64'd3);
            check("hold wdata", 64'(o_wdata1), 64'hDEADBEEF);
            check("hold wreg",  64'(o_wreg1),  64'd1);
            check("hold valid", 64'(o_valid1), 64'd1);
            check("hold cnt",   64'(o_cnt1),   64'd0);
        end
        $display("step hold done");

        // Bubble
        stall = 6'b010000;
        tick();
        check_one_clear("bubble");
        check("bubble cnt1", 64'(o_cnt1), 64'd1);
        check("bubble cnt2", 64'(o_cnt2), 64'd1);
        $display("step bubble done");

        // Address-0 dedup, lane-1 disabled, distinct addresses
        stall = '0;
        wd2 = {5'd0, 5'd0}; wreg2 = 2'b11;
        tick();
        check("addr0 wreg", 64'(o_wreg2), 64'b10);
        wd2 = {5'd0, 5'd0}; wreg2 = 2'b01;
        tick();
        check("addr0 lane1 off wreg", 64'(o_wreg2), 64'b01);
        wd2 = {5'd4, 5'd3}; wreg2 = 2'b11;
        tick();
        check("distinct wreg", 64'(o_wreg2), 64'b11);
        $display("step dedup done");

        // HI/LO load then bubble
        mem_hilo = 1'b1; mem_hi = 32'h1; mem_lo = 32'h2;
        tick();
        check("hilo flag", 64'(o_hilo1), 64'd1);
        check("hilo hi",   64'(o_hi1),   64'd1);
        check("hilo lo",   64'(o_lo1),   64'd2);
        stall = 6'b010000;
        tick();
        check("hilo bubble flag", 64'(o_hilo1), 64'd0);
        check("hilo bubble hi",   64'(o_hi1),   64'd0);
        check("hilo bubble lo",   64'(o_lo1),   64'd0);
        check("hilo bubble cnt",  64'(o_cnt1),  64'd2);
        mem_hilo = 1'b0; mem_hi = '0; mem_lo = '0;
        $display("step hilo done");

        // Flush beats bubble; counter untouched
        stall = '0; wd1 = 5'd5; wreg1 = 1'b1; wdata1 = 32'hAAAA5555;
        tick();
        check("preflush valid", 64'(o_valid1), 64'd1);
        flush = 1'b1; stall = 6'b010000;
        tick();
        check_one_clear("flush bubble");
        check("flush cnt", 64'(o_cnt1), 64'd2);
        $display("step flush/bubble done");

        // Flush beats hold
        flush = 1'b0; stall = '0;
        tick();
        flush = 1'b1; stall = 6'b110000;
        tick();
        check_one_clear("flush hold");
        check("flush hold cnt", 64'(o_cnt1), 64'd2);
        $display("step flush/hold done");

        // Reset beats flush and hold
        flush = 1'b0; stall = '0;
        tick();
        check("prereset valid", 64'(o_valid1), 64'd1);
        rst = 1'b1; flush = 1'b1; stall = 6'b110000;
        tick();
        rst = 1'b0; flush = 1'b0;
        check_one_clear("rst flush hold");
        check("rst cnt1",   64'(o_cnt1),   64'd0);
        check("rst cnt2",   64'(o_cnt2),   64'd0);
        check("rst valid2", 64'(o_valid2), 64'd0);
        $display("step reset priority done");

        // Saturation on the 2-bit counter
        stall = 6'b010000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("sat cnt2 #%0d", i), 64'(o_cnt2), (i < 3) ? 64'(i) : 64'd3);
        end
        check("nosat cnt1", 64'(o_cnt1), 64'd5);
        $display("step saturation done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
Parameters: name, default, meaning.
REQ-001 SHALL provide parameter LANES, default 1, number of writeback lanes (1..4).
REQ-002 SHALL provide parameter DW, default 32, data width per lane and of hi/lo.
REQ-003 SHALL provide parameter AW, default 5, register-address width per lane.
REQ-004 SHALL provide parameter STAGE, default 4, index of this stage in the stall vector (0..4).
REQ-005 SHALL provide parameter CW, default 16, bubble-counter width.

Ports: name, direction, width, meaning. Clock and reset come first.
REQ-006 SHALL have clk, input, 1, the single clock; all state updates on the rising edge.
REQ-007 SHALL have rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have stall, input, 6, pipeline stall vector.
REQ-009 SHALL have flush, input, 1, exception/branch flush of this stage.
REQ-010 SHALL have mem_wd, input, LANES*AW, destination address per lane; lane i occupies bits [i*AW +: AW].
REQ-011 SHALL have mem_wreg, input, LANES, write enable per lane.
REQ-012 SHALL have mem_wdata, input, LANES*DW, write data per lane; lane i occupies bits [i*DW +: DW].
REQ-013 SHALL have mem_hi and mem_lo, input, DW each, and mem_hilo, input, 1, the hi/lo write request.
REQ-014 SHALL have outputs wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo and wb_hilo, registered, with widths equal to their mem_* counterparts.
REQ-015 SHALL have wb_valid, output, 1, set when the stage holds a loaded instruction group.
REQ-016 SHALL have bubble_cnt, output, CW, the count of bubbles inserted at this stage.

Function
REQ-017 SHALL evaluate the stage update with priority rst > flush > bubble > hold > load.
REQ-018 Bubble SHALL occur when stall[STAGE]=1 and stall[STAGE+1]=0; the stage then clears (zero data, wreg/hilo disabled, wb_valid=0).
REQ-019 Hold SHALL occur when stall[STAGE]=1 and stall[STAGE+1]=1; all wb_* and wb_valid are retained unchanged.
REQ-020 Load SHALL occur when stall[STAGE]=0; every wb_* takes its mem_* value and wb_valid=1, with latency exactly 1 cycle.
REQ-021 Flush SHALL clear the stage exactly as a bubble does, regardless of stall; a flush SHALL NOT increment bubble_cnt.
REQ-022 On load with duplicate destinations (lanes i<j, both wreg=1, equal wd), lane i's wb_wreg SHALL be 0; the highest-numbered lane wins. Its wd and wdata are still captured.
REQ-023 Duplicate detection SHALL include address 0: lanes writing address 0 are deduplicated like any other address.
REQ-024 bubble_cnt SHALL increment by 1 on each bubble cycle, saturate at 2^CW-1, and never wrap.
REQ-025 bubble_cnt SHALL be unaffected by hold, load and flush.
REQ-026 With LANES=1, STAGE=4, behaviour of the wb_* outputs SHALL be cycle-identical to the existing MEM/WB register.
REQ-027 The block SHALL be purely registered outputs, with no combinational path from any input to any output.

Reset
REQ-028 On rst=1 at a rising edge, outputs SHALL take these values: wb_wd=0, wb_wreg=0, wb_wdata=0, wb_hi=0, wb_lo=0, wb_hilo=0, wb_valid=0, bubble_cnt=0.
REQ-029 Reset SHALL override flush and stall on the same edge, including a reset asserted while the stage is holding.
REQ-030 bubble_cnt SHALL be cleared only by rst.

Verification
REQ-031 Load test, LANES=1: stall=0, mem_wd=5'd3, mem_wreg=1, mem_wdata=32'hDEADBEEF -> next cycle wb_wd=3, wb_wreg=1, wb_wdata=DEADBEEF, wb_valid=1.
REQ-032 Hold/bubble test: load A, then stall=6'b110000 for 3 cycles -> A held, bubble_cnt=0; then stall=6'b010000 -> outputs zero, wb_valid=0, bubble_cnt=1.
REQ-033 Collision test, LANES=2: mem_wd={5'd7,5'd7}, mem_wreg=2'b11 -> wb_wreg=2'b10.
REQ-034 Address-0 test, LANES=2: mem_wd={5'd0,5'd0}, mem_wreg=2'b11 -> wb_wreg=2'b10 (lane 0 suppressed per REQ-023).
REQ-035 Flush test: flush=1 together with stall=6'b010000 -> stage cleared, bubble_cnt unchanged; rst together with flush -> all outputs 0.
REQ-036 Saturation test, CW=2: 5 bubble cycles -> bubble_cnt sequence 1,2,3,3,3.
REQ-037 HI/LO test: mem_hilo=1, mem_hi=32'h1, mem_lo=32'h2 with load -> wb_hilo=1, wb_hi=1, wb_lo=2; bubble next cycle -> all three 0.
